// File: rtl/seg7_pkg.sv
// ============================================================================
// Module   : seg7_pkg
// Brief    : Shared scan-FSM states, blank pattern and hex segment table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for nibble values 0..F
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

`default_nettype wire

// File: rtl/seg7_scan_hex2seg.sv
// ============================================================================
// Module   : hex2seg
// Brief    : Combinational nibble to active-low seven-segment decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex2seg
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nib_i];

endmodule

`default_nettype wire

// File: rtl/seg7_scan.sv
// ============================================================================
// Module   : seg7_scan
// Brief    : 4-digit multiplexed 7-seg driver with anti-ghost blanking and
//            frame-synchronous display buffer update.
//            Optional macro SEG7_LZB_EN enables leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan
  import seg7_pkg::*;
#(
  parameter int BLANK_CYCLES  = 4,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  dig_sel,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        pending,
  output logic        load_ack
);

  localparam logic [7:0] CNT_LAST = 8'(BLANK_CYCLES - 1);
  localparam logic [3:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [1:0]  cur_dig_q;
  logic [1:0]  prev_sel_q;
  logic [15:0] disp_buf_q;
  logic [3:0]  disp_dp_q;
  logic [15:0] pend_buf_q;
  logic [3:0]  pend_dp_q;
  logic        pending_q;
  logic        load_ack_q;
  logic [3:0]  an_q;
  logic [6:0]  seg_q;
  logic        dp_q;

  logic [3:0]  nib_d;
  logic [6:0]  dec_d;
  logic        lz_blank_d;
  logic [3:0]  onehot_d;
  logic [3:0]  an_drive_d;
  logic [6:0]  seg_drive_d;
  logic        dp_drive_d;
  logic        boundary_d;

  assign nib_d = disp_buf_q[{cur_dig_q, 2'b00} +: 4];

  hex2seg u_hex2seg (
    .nib_i (nib_d),
    .seg_o (dec_d)
  );

`ifdef SEG7_LZB_EN
  // lz_d[k]: nibbles k..3 all zero; digit 0 always shows
  logic [3:0] lz_d;
  assign lz_d[3] = (disp_buf_q[15:12] == 4'h0);
  assign lz_d[2] = lz_d[3] && (disp_buf_q[11:8] == 4'h0);
  assign lz_d[1] = lz_d[2] && (disp_buf_q[7:4] == 4'h0);
  assign lz_d[0] = 1'b0;
  assign lz_blank_d = lz_d[cur_dig_q];
`else
  assign lz_blank_d = 1'b0;
`endif

  assign onehot_d    = 4'b0001 << cur_dig_q;
  assign an_drive_d  = (AN_ACTIVE_LOW != 0) ? ~onehot_d : onehot_d;
  assign seg_drive_d = lz_blank_d ? SEG_OFF : dec_d;
  assign dp_drive_d  = ~disp_dp_q[cur_dig_q];

  assign boundary_d  = (prev_sel_q == 2'd3) && (dig_sel == 2'd0);

  // Scan FSM; pins are registered from the state held before each edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_BLANK;
      cnt_q     <= 8'd0;
      cur_dig_q <= 2'd0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_OFF;
      dp_q      <= 1'b1;
    end else begin
      case (state_q)
        S_BLANK: begin
          an_q  <= AN_OFF;
          seg_q <= SEG_OFF;
          dp_q  <= 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q   <= S_DRIVE;
            cur_dig_q <= dig_sel;
            cnt_q     <= 8'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DRIVE: begin
          an_q  <= an_drive_d;
          seg_q <= seg_drive_d;
          dp_q  <= dp_drive_d;
          if (dig_sel != cur_dig_q) begin
            state_q <= S_BLANK;
            cnt_q   <= 8'd0;
          end
        end
        default: begin
          state_q <= S_BLANK;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

  // Loads wait for the 3->0 frame boundary so a frame never shows mixed data
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_sel_q <= 2'd0;
      disp_buf_q <= 16'h0000;
      disp_dp_q  <= 4'h0;
      pend_buf_q <= 16'h0000;
      pend_dp_q  <= 4'h0;
      pending_q  <= 1'b0;
      load_ack_q <= 1'b0;
    end else begin
      prev_sel_q <= dig_sel;
      load_ack_q <= 1'b0;
      if (load && boundary_d) begin
        disp_buf_q <= value;
        disp_dp_q  <= dp_in;
        pending_q  <= 1'b0;
        load_ack_q <= 1'b1;
      end else if (boundary_d && pending_q) begin
        disp_buf_q <= pend_buf_q;
        disp_dp_q  <= pend_dp_q;
        pending_q  <= 1'b0;
        load_ack_q <= 1'b1;
      end else if (load) begin
        pend_buf_q <= value;
        pend_dp_q  <= dp_in;
        pending_q  <= 1'b1;
      end
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;
  assign pending  = pending_q;
  assign load_ack = load_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan.sv
// ============================================================================
// Module   : tb_seg7_scan
// Brief    : Self-checking bench for seg7_scan against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan;

  localparam int B    = 4;
  localparam int ALOW = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  dig_sel;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        pending;
  logic        load_ack;

  always #5 clk = ~clk;

  seg7_scan #(
    .BLANK_CYCLES  (B),
    .AN_ACTIVE_LOW (ALOW)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .dig_sel  (dig_sel),
    .load     (load),
    .value    (value),
    .dp_in    (dp_in),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .pending  (pending),
    .load_ack (load_ack)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int hexseg(input int n);
    case (n)
      0: return 'h40;  1: return 'h79;  2: return 'h24;  3: return 'h30;
      4: return 'h19;  5: return 'h12;  6: return 'h02;  7: return 'h78;
      8: return 'h00;  9: return 'h10; 10: return 'h08; 11: return 'h03;
     12: return 'h46; 13: return 'h21; 14: return 'h06; default: return 'h0E;
    endcase
  endfunction

  function automatic bit lz_blank(input int disp, input int dig);
`ifdef SEG7_LZB_EN
    return (dig > 0) && ((disp >> (4 * dig)) == 0);
`else
    return 1'b0;
`endif
  endfunction

  // Model: a blank interval lasts B edges after it starts, then the digit
  // selected at that moment is driven until dig_sel moves away from it.
  int m_cycle = 0;
  bit m_drive;
  int m_dig, m_blank_start, m_prev;
  int m_disp, m_ddp, m_pend, m_pdp;
  bit m_pending, m_ack;
  int e_an, e_seg, e_dp;

  task automatic model_edge();
    bit boundary;
    if (rst) begin
      m_drive = 0; m_dig = 0; m_blank_start = m_cycle; m_prev = 0;
      m_disp = 0; m_ddp = 0; m_pend = 0; m_pdp = 0;
      m_pending = 0; m_ack = 0;
      e_an = ALOW ? 15 : 0; e_seg = 'h7F; e_dp = 1;
    end else begin
      if (m_drive) begin
        e_an  = ALOW ? (15 ^ (1 << m_dig)) : (1 << m_dig);
        e_seg = lz_blank(m_disp, m_dig) ? 'h7F : hexseg((m_disp >> (4 * m_dig)) & 15);
        e_dp  = ((m_ddp >> m_dig) & 1) ? 0 : 1;
      end else begin
        e_an = ALOW ? 15 : 0; e_seg = 'h7F; e_dp = 1;
      end
      boundary = (m_prev == 3) && (dig_sel == 2'd0);
      m_ack = 0;
      if (boundary && (load || m_pending)) begin
        m_disp    = load ? int'(value) : m_pend;
        m_ddp     = load ? int'(dp_in) : m_pdp;
        m_pending = 0;
        m_ack     = 1;
      end else if (load) begin
        m_pend = int'(value); m_pdp = int'(dp_in); m_pending = 1;
      end
      m_prev = int'(dig_sel);
      if (m_drive) begin
        if (int'(dig_sel) != m_dig) begin
          m_drive = 0; m_blank_start = m_cycle;
        end
      end else if (m_cycle - m_blank_start == B) begin
        m_drive = 1; m_dig = int'(dig_sel);
      end
    end
    m_cycle++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_val("an",       32'(an),       32'(e_an));
    check_val("seg",      32'(seg),      32'(e_seg));
    check_val("dp",       32'(dp),       32'(e_dp));
    check_val("pending",  32'(pending),  32'(m_pending));
    check_val("load_ack", 32'(load_ack), 32'(m_ack));
  endtask

  task automatic hold(input logic [1:0] s, input int n);
    dig_sel = s;
    repeat (n) tick();
  endtask

  initial begin
    int hold_left;
    rst = 1'b1; load = 1'b0; dig_sel = 2'd0; value = 16'h0; dp_in = 4'h0;

    // Reset state and first digit
    tick();
    check_val("rst_an", 32'(an), 32'h0F);
    check_val("rst_seg", 32'(seg), 32'h7F);
    check_val("rst_dp", 32'(dp), 32'h1);
    rst = 1'b0;
    repeat (B + 1) tick();
    check_val("first_an", 32'(an), 32'b1110);
    check_val("first_seg", 32'(seg), 32'h40);

    // 0->1 blanking
    dig_sel = 2'd1;
    tick();
    repeat (B) begin
      tick();
      check_val("blank_an", 32'(an), 32'h0F);
    end
    tick();
    check_val("dig1_an", 32'(an), 32'b1101);

    // Deferred load mid-frame
    load = 1'b1; value = 16'h12AF; dp_in = 4'b0001;
    tick();
    load = 1'b0;
    check_val("pend_set", 32'(pending), 32'h1);
    hold(2'd2, B + 2);
    hold(2'd3, B + 2);
    check_val("pend_hold", 32'(pending), 32'h1);
    dig_sel = 2'd0;
    tick();
    check_val("ack_pulse", 32'(load_ack), 32'h1);
    check_val("pend_clr", 32'(pending), 32'h0);
    repeat (B + 1) tick();
    check_val("d0_seg", 32'(seg), 32'h0E);
    check_val("d0_dp", 32'(dp), 32'h0);
    hold(2'd1, B + 2);
    hold(2'd2, B + 2);
    hold(2'd3, B + 2);
    check_val("d3_an", 32'(an), 32'b0111);
    check_val("d3_seg", 32'(seg), 32'h79);

    // Two loads before a boundary: last wins, single ack
    load = 1'b1; value = 16'h1111; dp_in = 4'h0;
    tick();
    value = 16'h2222;
    tick();
    load = 1'b0;
    tick();
    dig_sel = 2'd0;
    tick();
    check_val("ack2", 32'(load_ack), 32'h1);
    tick();
    check_val("single_ack", 32'(load_ack), 32'h0);
    repeat (B) tick();
    check_val("d0_2222", 32'(seg), 32'h24);
    hold(2'd1, B + 2);
    check_val("d1_2222", 32'(seg), 32'h24);
    hold(2'd2, B + 2);
    check_val("d2_2222", 32'(seg), 32'h24);
    hold(2'd3, B + 2);
    check_val("d3_2222", 32'(seg), 32'h24);

    // Load coincident with the 3->0 boundary
    dig_sel = 2'd0; load = 1'b1; value = 16'h0005; dp_in = 4'h0;
    tick();
    load = 1'b0;
    check_val("coin_ack", 32'(load_ack), 32'h1);
    check_val("coin_pend", 32'(pending), 32'h0);
    repeat (B + 1) tick();
    check_val("coin_d0", 32'(seg), 32'h12);
    hold(2'd1, B + 2);
`ifdef SEG7_LZB_EN
    check_val("coin_d1_lzb", 32'(seg), 32'h7F);
`else
    check_val("coin_d1", 32'(seg), 32'h40);
`endif

    // Reset while a load is pending
    load = 1'b1; value = 16'hBEEF; dp_in = 4'hF;
    tick();
    load = 1'b0;
    check_val("pre_rst_pend", 32'(pending), 32'h1);
    rst = 1'b1; dig_sel = 2'd0;
    tick();
    rst = 1'b0;
    check_val("rst_pend", 32'(pending), 32'h0);
    check_val("rst_an2", 32'(an), 32'h0F);
    repeat (B + 1) tick();
    check_val("rst_buf", 32'(seg), 32'h40);

    // Randomized scanning, jumps, loads and occasional resets
    hold_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_left == 0) begin
        if ($urandom_range(7) == 0) dig_sel = 2'($urandom_range(3));
        else dig_sel = dig_sel + 2'd1;
        hold_left = $urandom_range(12, 1);
      end
      hold_left--;
      load  = ($urandom_range(9) == 0);
      value = 16'($urandom);
      dp_in = 4'($urandom);
      rst   = ($urandom_range(399) == 0);
      tick();
    end
    rst = 1'b0; load = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter BLANK_CYCLES, default 4, meaning anti-ghost blank length in clk cycles after each digit change; legal range 1..255.
REQ-002 SHALL have parameter AN_ACTIVE_LOW, default 1, meaning `an` is active-low when 1 and active-high when 0.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port dig_sel  input  2  digit index from the scan divider; cycles 0,1,2,3,0.
REQ-006 SHALL have port load  input  1  one-cycle strobe capturing `value` and `dp_in`.
REQ-007 SHALL have port value  input  16  four hex nibbles; digit k = value[4k+3:4k].
REQ-008 SHALL have port dp_in  input  4  decimal point per digit; bit k = digit k, 1 = lit.
REQ-009 SHALL have port an  output  4  digit anode enables; one-hot per AN_ACTIVE_LOW, or all inactive.
REQ-010 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port dp  output  1  decimal point, active-low.
REQ-012 SHALL have port pending  output  1  high while a loaded value awaits the frame boundary.
REQ-013 SHALL have port load_ack  output  1  one-cycle pulse when a value enters the display buffer.

Function
REQ-014 SHALL register dig_sel as prev_sel every cycle.
REQ-015 SHALL implement FSM {S_BLANK, S_DRIVE}.
- S_BLANK: counts 0..BLANK_CYCLES-1, then goes to S_DRIVE and latches cur_dig <= dig_sel.
- S_DRIVE: if dig_sel != cur_dig, goes to S_BLANK with counter 0.
REQ-016 SHALL drive all anodes inactive, seg=7'h7F and dp=1 in S_BLANK.
REQ-017 SHALL drive in S_DRIVE: anode cur_dig active, seg = decode(disp_buf nibble cur_dig), dp = ~disp_dp[cur_dig].
REQ-018 SHALL register an/seg/dp: one clk latency from state/buffer to pins.
REQ-019 SHALL hold load in a pending buffer; pending=1 in the cycle after load.
REQ-020 SHALL overwrite the pending buffer on a new load while pending=1; the last load wins.
REQ-021 SHALL treat a frame boundary as prev_sel==3 && dig_sel==0.
REQ-022 SHALL apply the boundary with pending=1 as follows: disp_buf <= pend buffer, pending <= 0, and load_ack=1 for the next cycle.
REQ-023 SHALL handle load and boundary in the same cycle as follows: `value`/`dp_in` go directly to disp_buf, pending <= 0, and load_ack pulses.
REQ-024 SHALL use hex decode (active-low) 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-025 SHALL react to any dig_sel change, including non-sequential jumps, with a full blank period; only 3->0 is a frame boundary.

Reset
REQ-026 SHALL set the following on rst=1 at a clk edge:
- state S_BLANK, counter 0, cur_dig 0, prev_sel 0.
- disp_buf 0, disp_dp 0, pending 0, load_ack 0.
- an all inactive, seg 7'h7F, dp 1.
REQ-027 SHALL give rst priority over load and boundary; pending data SHALL be discarded when rst is asserted mid-operation.

Configuration
REQ-028 SHALL honour macro SEG7_LZB_EN (leading-zero blanking).
- Defined: digit k in 3..1 shows seg=7'h7F when nibbles k..3 are all zero; dp is still per disp_dp; digit 0 is never blanked.
- Undefined: all digits decode normally.

Structure
REQ-029 SHALL define state encodings, the SEG_OFF constant and the 16-entry segment table in shared package seg7_pkg.
REQ-030 SHALL place the combinational nibble-to-segment decode in sub-module hex2seg (4-bit in, 7-bit active-low out).

Verification
REQ-031 SHALL cover: reset, then dig_sel held 0 -> after BLANK_CYCLES+1 clk, an=4'b1110, seg=7'h40.
REQ-032 SHALL cover: dig_sel 0->1 -> an=4'hF for BLANK_CYCLES cycles, then an=4'b1101.
REQ-033 SHALL cover: load value=16'h12AF mid-frame -> pending=1; display unchanged until 3->0; then load_ack pulse, and digit0 seg=7'h0E, digit3 seg=7'h79.
REQ-034 SHALL cover: two loads, 16'h1111 then 16'h2222, before a boundary -> single ack; all digits seg=7'h24.
REQ-035 SHALL cover: load 16'h0005 coincident with 3->0 -> immediate ack, pending stays 0; with SEG7_LZB_EN, digits 3..1 seg=7'h7F and digit0 seg=7'h12.
REQ-036 SHALL cover: rst asserted while pending=1 -> pending=0, disp_buf=0, an all inactive on the next edge.
